// File: rtl/mac_accumulator.sv
// Signed 8x8 multiply-accumulate with chunked accumulation, saturation and a
// first-word-fall-through result FIFO with overflow detection.
module mac_accumulator #(
  parameter int unsigned ACC_W      = 32,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic [7:0]       ifm_data_i,
  input  logic [7:0]       filter_data_i,
  input  logic             data_valid_i,
  input  logic             chunk_end_i,
  input  logic             chunk_last_i,
  output logic [ACC_W-1:0] psum_o,
  output logic             psum_sat_o,
  output logic             psum_valid_o,
  input  logic             psum_ready_i,
  output logic             stall_o,
  output logic             drop_err_o
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  // Stage 1: registered product and its qualifiers
  logic signed [15:0] prod_q;
  logic               valid_q;
  logic               end_q;
  logic               last_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prod_q  <= '0;
      valid_q <= 1'b0;
      end_q   <= 1'b0;
      last_q  <= 1'b0;
    end else if (clear_i) begin
      prod_q  <= '0;
      valid_q <= 1'b0;
      end_q   <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      prod_q  <= $signed(ifm_data_i) * $signed(filter_data_i);
      valid_q <= data_valid_i;
      end_q   <= chunk_end_i;
      last_q  <= chunk_last_i;
    end
  end

  // Stage 2: saturating accumulate; one guard bit exposes signed overflow
  logic [ACC_W-1:0] acc_q;
  logic             sat_q;
  logic [ACC_W:0]   addend;
  logic [ACC_W:0]   sum_wide;
  logic             ovf;
  logic [ACC_W-1:0] acc_next;
  logic             sat_next;
  logic             push;

  always_comb begin
    addend   = '0;
    if (valid_q) addend = {{(ACC_W-15){prod_q[15]}}, prod_q};
    sum_wide = {acc_q[ACC_W-1], acc_q} + addend;
    ovf      = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];
    acc_next = sum_wide[ACC_W-1:0];
    if (ovf) acc_next = sum_wide[ACC_W] ? ACC_MIN : ACC_MAX;
    sat_next = sat_q | ovf;
  end

  assign push = end_q & last_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= '0;
      sat_q <= 1'b0;
    end else if (clear_i || push) begin
      acc_q <= '0;
      sat_q <= 1'b0;
    end else begin
      acc_q <= acc_next;
      sat_q <= sat_next;
    end
  end

  // Result FIFO: entries hold {sat, sum}
  logic [ACC_W:0]   mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             pop;
  logic             push_ok;
  logic             drop;

  assign full    = (count == CNT_W'(FIFO_DEPTH));
  assign pop     = (count != '0) & psum_ready_i;
  assign push_ok = push & (~full | pop);
  assign drop    = push & full & ~pop;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      drop_err_o <= 1'b0;
    end else if (clear_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      drop_err_o <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (drop) drop_err_o <= 1'b1;
    end
  end

  // Storage needs no reset: outputs are gated by the count
  always_ff @(posedge clk_i) begin
    if (push_ok && !clear_i) mem[wr_ptr] <= {sat_next, acc_next};
  end

  logic [ACC_W:0] head;

  always_comb begin
    head         = mem[rd_ptr];
    psum_valid_o = (count != '0);
    psum_o       = '0;
    psum_sat_o   = 1'b0;
    if (psum_valid_o) begin
      psum_o     = head[ACC_W-1:0];
      psum_sat_o = head[ACC_W];
    end
  end

  assign stall_o = (count >= CNT_W'(FIFO_DEPTH - 2));

endmodule
